// File: rtl/gfx_pkg.sv
// Shared graphics-subsystem definitions: arbiter state encoding and port-index helpers.
package gfx_pkg;

    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_ARB    = 1'b0;
    localparam logic [STATE_W-1:0] ST_LOCKED = 1'b1;

    // Width of a port index for a given port count; never narrower than one bit.
    function automatic int unsigned port_idx_w(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin priority selector: first asserted request at or after ptr, wrapping.
module rr_select
    import gfx_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int N = int'(NUM_PORTS);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == int'(ptr) + k || i + N == int'(ptr) + k)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Multi-port VRAM arbiter: round-robin access with an exclusive lock mode and
// out-of-range detection in front of a single-ported 1-cycle-latency VRAM.
module vram_arbiter
    import gfx_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 2048
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_PORTS-1:0]        REQ_ENABLE,
    input  logic [NUM_PORTS-1:0]        REQ_WRITE,
    input  logic [NUM_PORTS-1:0]        REQ_LOCK,
    input  logic [NUM_PORTS*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_PORTS*DATA_W-1:0] REQ_DATA_W,
    output logic [NUM_PORTS-1:0]        REQ_GRANT,
    output logic [DATA_W-1:0]           RD_DATA,
    output logic [NUM_PORTS-1:0]        RD_VALID,
    output logic [NUM_PORTS-1:0]        ERR,
    output logic                        VRAM_ENABLE,
    output logic                        VRAM_WRITE,
    output logic [ADDR_W-1:0]           VRAM_ADDR,
    output logic [DATA_W-1:0]           VRAM_DATA_W,
    input  logic [DATA_W-1:0]           VRAM_DATA_R
);

    localparam int unsigned IDX_W = port_idx_w(NUM_PORTS);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_PORTS-1:0] rr_grant, grant;
    logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic                 transfer, in_range, grant_lock;

    rr_select #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_rr_select (
        .req  (REQ_ENABLE),
        .ptr  (rr_ptr_q),
        .grant(rr_grant)
    );

    always_comb begin
        grant = '0;
        if (RESET) begin
            if (state_q == ST_LOCKED) begin
                grant[owner_q] = REQ_ENABLE[owner_q];
            end else begin
                grant = rr_grant;
            end
        end
    end

    always_comb begin
        grant_idx   = '0;
        VRAM_WRITE  = 1'b0;
        VRAM_ADDR   = '0;
        VRAM_DATA_W = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant[i]) begin
                grant_idx   = IDX_W'(i);
                VRAM_WRITE  = REQ_WRITE[i];
                VRAM_ADDR   = REQ_ADDR[i*ADDR_W +: ADDR_W];
                VRAM_DATA_W = REQ_DATA_W[i*DATA_W +: DATA_W];
            end
        end
    end

    assign transfer    = |grant;
    assign grant_lock  = |(grant & REQ_LOCK);
    assign in_range    = 32'(VRAM_ADDR) < DEPTH;
    assign VRAM_ENABLE = transfer && in_range;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (state_q == ST_LOCKED) begin
            // Owner keeps the bus for the cycle LOCK is seen low; release takes effect after.
            if (!REQ_LOCK[owner_q]) begin
                state_d  = ST_ARB;
                rr_ptr_d = IDX_W'(wrap_inc(32'(owner_q), NUM_PORTS));
            end
        end else if (transfer) begin
            rr_ptr_d = IDX_W'(wrap_inc(32'(grant_idx), NUM_PORTS));
            if (grant_lock) begin
                state_d = ST_LOCKED;
                owner_d = grant_idx;
            end
        end
        rd_valid_d = (transfer && in_range && !VRAM_WRITE) ? grant : '0;
        err_d      = (transfer && !in_range) ? grant : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            rd_valid_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Returns are masked during reset so a requester never sees one for a pre-reset access.
    assign REQ_GRANT = grant;
    assign RD_DATA   = VRAM_DATA_R;
    assign RD_VALID  = rd_valid_q & {NUM_PORTS{RESET}};
    assign ERR       = err_q & {NUM_PORTS{RESET}};

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter (4 ports, 12-bit address, 2048 words) with a
// behavioural VRAM and a queue of expected read/error returns.
module tb_vram_arbiter;

    typedef struct packed {
        logic [3:0]  rv;
        logic [3:0]  err;
        logic [15:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en, wr, lk;
    logic [11:0] addr [4];
    logic [15:0] wdata [4];
    logic [47:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  grant, rd_valid, err;
    logic [15:0] rd_data;
    logic        vram_enable, vram_write;
    logic [11:0] vram_addr;
    logic [15:0] vram_data_w, vram_data_r;

    logic [15:0] mem [2048];
    logic [15:0] shadow [2048];
    ret_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};
    assign req_data = {wdata[3], wdata[2], wdata[1], wdata[0]};

    always #5 clk = ~clk;

    vram_arbiter #(
        .NUM_PORTS(4),
        .ADDR_W   (12),
        .DATA_W   (16),
        .DEPTH    (2048)
    ) dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .REQ_ENABLE (en),
        .REQ_WRITE  (wr),
        .REQ_LOCK   (lk),
        .REQ_ADDR   (req_addr),
        .REQ_DATA_W (req_data),
        .REQ_GRANT  (grant),
        .RD_DATA    (rd_data),
        .RD_VALID   (rd_valid),
        .ERR        (err),
        .VRAM_ENABLE(vram_enable),
        .VRAM_WRITE (vram_write),
        .VRAM_ADDR  (vram_addr),
        .VRAM_DATA_W(vram_data_w),
        .VRAM_DATA_R(vram_data_r)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i) ^ 16'hA5C3;
    endfunction

    // Behavioural single-port VRAM, one cycle read latency.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
        forever begin
            @(posedge clk);
            if (vram_enable) begin
                if (vram_write) mem[vram_addr[10:0]] <= vram_data_w;
                else            vram_data_r <= mem[vram_addr[10:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic tick(input logic [3:0] exp_grant, input string tag);
        ret_t        prev, nxt;
        int          p;
        logic [11:0] a;
        logic        exp_ven;
        #1;
        prev = sb.pop_front();
        if (!rst_n) begin
            prev.rv  = '0;
            prev.err = '0;
        end
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(prev.rv));
        check({tag, " err"}, 32'(err), 32'(prev.err));
        if (prev.rv != 0) check({tag, " rd_data"}, 32'(rd_data), 32'(prev.data));
        check({tag, " grant"}, 32'(grant), 32'(exp_grant));
        nxt     = '0;
        exp_ven = 1'b0;
        p       = -1;
        for (int i = 0; i < 4; i++) if (exp_grant[i]) p = i;
        if (p >= 0) begin
            a = addr[p];
            check({tag, " vram_addr"}, 32'(vram_addr), 32'(a));
            check({tag, " vram_write"}, 32'(vram_write), 32'(wr[p]));
            if (a >= 12'd2048) begin
                nxt.err = exp_grant;
            end else begin
                exp_ven = 1'b1;
                if (wr[p]) begin
                    shadow[a[10:0]] = wdata[p];
                end else begin
                    nxt.rv   = exp_grant;
                    nxt.data = shadow[a[10:0]];
                end
            end
        end
        check({tag, " vram_enable"}, 32'(vram_enable), 32'(exp_ven));
        sb.push_back(nxt);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) shadow[i] = pat(i);
        for (int i = 0; i < 4; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        sb.push_back('0);
        rst_n = 1'b0;
        en    = 4'b0000;
        wr    = 4'b0000;
        lk    = 4'b0000;
        tick(4'b0000, "reset idle");
        en = 4'b0011;
        tick(4'b0000, "reset req");

        // Two readers alternate from reset.
        rst_n   = 1'b1;
        addr[0] = 12'd5;
        addr[1] = 12'd9;
        tick(4'b0001, "alt0");
        tick(4'b0010, "alt1");
        tick(4'b0001, "alt2");
        tick(4'b0010, "alt3");
        en = 4'b0001;
        tick(4'b0001, "solo0");
        en = 4'b0000;
        tick(4'b0000, "idle");
        en = 4'b0011;
        tick(4'b0010, "after idle");

        // Port 1 locks with a write and holds LOCK for four cycles.
        en       = 4'b0010;
        wr       = 4'b0010;
        lk       = 4'b0010;
        addr[1]  = 12'h010;
        wdata[1] = 16'hBEEF;
        tick(4'b0010, "lock write");
        addr[0] = 12'h010;
        wr      = 4'b0000;
        en      = 4'b0011;
        tick(4'b0010, "owner read");
        en = 4'b0001;
        tick(4'b0000, "lock hold a");
        tick(4'b0000, "lock hold b");
        lk = 4'b0000;
        tick(4'b0000, "lock drop");
        tick(4'b0001, "post lock");

        // Last valid word, then first out-of-range word.
        addr[0] = 12'd2047;
        tick(4'b0001, "addr max");
        addr[0] = 12'd2048;
        tick(4'b0001, "addr oob");
        en       = 4'b0100;
        wr       = 4'b0100;
        addr[2]  = 12'hFFF;
        wdata[2] = 16'h1234;
        tick(4'b0100, "oob write");

        // All four request with rr_ptr at 3.
        en      = 4'b1111;
        wr      = 4'b0000;
        addr[0] = 12'd100;
        addr[1] = 12'd200;
        addr[2] = 12'd300;
        addr[3] = 12'd400;
        tick(4'b1000, "rr3");
        tick(4'b0001, "rr0");
        tick(4'b0010, "rr1");
        tick(4'b0100, "rr2");
        tick(4'b1000, "rr3 again");

        // Reset while port 1 holds the lock with a read outstanding.
        en = 4'b0010;
        lk = 4'b0010;
        tick(4'b0010, "lock read");
        en = 4'b0011;
        tick(4'b0010, "locked read");
        rst_n = 1'b0;
        tick(4'b0000, "reset in lock");
        tick(4'b0000, "reset hold");
        rst_n = 1'b1;
        tick(4'b0001, "post reset");
        en = 4'b0000;
        lk = 4'b0000;
        tick(4'b0000, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
